// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Frame layout: CNT_HI, CNT_LO, N x (DAT_HI, DAT_LO), CHK.
package imem_loader_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int BYTE_W = 8;

    localparam int POS_CNT_HI = 0;
    localparam int POS_CNT_LO = 1;
    localparam int POS_DATA   = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT_HI = 3'd1,
        CNT_LO = 3'd2,
        DAT_HI = 3'd3,
        DAT_LO = 3'd4,
        CHK    = 3'd5,
        FIN    = 3'd6
    } state_t;

    // Total bytes on the wire for a frame carrying n words.
    function automatic int frame_bytes(input int n);
        return POS_DATA + 2 * n + 1;
    endfunction

endpackage

// File: rtl/imem_word_asm.sv
// Byte-to-word assembler: latches the high byte, builds big-endian words
// and keeps the running mod-256 checksum of every accepted byte.
module imem_word_asm
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              acc_sum,
    input  logic              acc_hi,
    input  logic              acc_lo,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [DATA_W-1:0] word,
    output logic [BYTE_W-1:0] sum
);

    logic [BYTE_W-1:0] hi;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi   <= '0;
            word <= '0;
            sum  <= '0;
        end else begin
            if (clr)
                sum <= '0;
            else if (acc_sum)
                sum <= sum + byte_in;
            if (acc_hi)
                hi <= byte_in;
            if (acc_lo)
                word <= {hi, byte_in};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a framed byte stream, writes
// words at consecutive addresses and releases cpu_hold on a good checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_vld,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              byte_rdy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] remaining;
    logic [BYTE_W-1:0] sum;
    logic              accept;
    logic              clr, acc_sum, acc_hi, acc_lo;
    logic              zero_count, last_word, chk_bad;

    assign accept     = byte_vld & byte_rdy;
    assign zero_count = (remaining[ADDR_W-1:BYTE_W] == '0) && (byte_in == '0);
    assign last_word  = (remaining == ADDR_W'(1));
    assign chk_bad    = (byte_in != sum);
    assign wr_addr    = addr;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: every signal written in an always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)  state_nxt = CNT_HI;
            CNT_HI:  if (accept) state_nxt = CNT_LO;
            CNT_LO:  if (accept) state_nxt = zero_count ? CHK : DAT_HI;
            DAT_HI:  if (accept) state_nxt = DAT_LO;
            DAT_LO:  if (accept) state_nxt = last_word ? CHK : DAT_HI;
            CHK:     if (accept) state_nxt = FIN;
            FIN:                 state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // byte_rdy depends on state alone so the sender never sees a loop through byte_vld.
    always_comb begin
        byte_rdy = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        clr      = 1'b0;
        acc_sum  = 1'b0;
        acc_hi   = 1'b0;
        acc_lo   = 1'b0;
        case (state)
            IDLE:           clr = start;
            CNT_HI, CNT_LO: begin byte_rdy = 1'b1; busy = 1'b1; acc_sum = accept; end
            DAT_HI:         begin byte_rdy = 1'b1; busy = 1'b1; acc_sum = accept; acc_hi = accept; end
            DAT_LO:         begin byte_rdy = 1'b1; busy = 1'b1; acc_sum = accept; acc_lo = accept; end
            CHK:            begin byte_rdy = 1'b1; busy = 1'b1; end
            FIN:            done = 1'b1;
            default:        ;
        endcase
    end

    // The write address advances on the edge that closes the write cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= BASE_ADDR;
            remaining <= '0;
            wr_en     <= 1'b0;
            err       <= 1'b0;
            cpu_hold  <= 1'b1;
        end else begin
            wr_en <= acc_lo;
            if (wr_en)
                addr <= addr + ADDR_W'(1);
            case (state)
                IDLE: if (start) begin
                    addr      <= BASE_ADDR;
                    remaining <= '0;
                    err       <= 1'b0;
                    cpu_hold  <= 1'b1;
                end
                CNT_HI: if (accept) remaining[ADDR_W-1:BYTE_W] <= byte_in;
                CNT_LO: if (accept) remaining[BYTE_W-1:0]      <= byte_in;
                DAT_LO: if (accept) remaining <= remaining - ADDR_W'(1);
                CHK: if (accept) begin
                    err      <= chk_bad;
                    cpu_hold <= chk_bad;
                end
                default: ;
            endcase
        end
    end

    imem_word_asm u_word_asm (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .acc_sum (acc_sum),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .byte_in (byte_in),
        .word    (wr_data),
        .sum     (sum)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; two instances (base 0 and
// base FFFF) see identical streams so address wrap is exercised on every frame.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam logic [1:0][15:0] BASES = {16'hFFFF, 16'h0000};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             byte_vld = 1'b0;
    logic [7:0]       byte_in = 8'h00;
    logic [1:0]       byte_rdy, wr_en, busy, done, err, cpu_hold;
    logic [1:0][15:0] wr_addr, wr_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          inst;
        int          cyc;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         wq[$];
    logic [15:0] frame_words[$];
    logic [1:0]  prev_wr = 2'b00;

    imem_loader #(.BASE_ADDR(16'h0000)) dut_a (
        .clk(clk), .rst(rst), .start(start), .byte_vld(byte_vld), .byte_in(byte_in),
        .byte_rdy(byte_rdy[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0]), .cpu_hold(cpu_hold[0])
    );

    imem_loader #(.BASE_ADDR(16'hFFFF)) dut_b (
        .clk(clk), .rst(rst), .start(start), .byte_vld(byte_vld), .byte_in(byte_in),
        .byte_rdy(byte_rdy[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1]), .cpu_hold(cpu_hold[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port monitor: logs every write and flags consecutive strobes.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (wr_en[k] === 1'b1) begin
                wq.push_back('{k, cyc, wr_addr[k], wr_data[k]});
                n_checks++;
                if (prev_wr[k] === 1'b1) begin
                    n_fail++;
                    $display("FAIL wr_en_consecutive inst=%0d cyc=%0d got 2 back-to-back strobes, required isolated", k, cyc);
                end
            end
        end
        prev_wr = wr_en;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish within time limit, required completion");
        $fatal(1, "watchdog");
    end

    // Offers one byte, optionally preceded by stall cycles; returns the edge index of the handshake.
    task automatic drive_byte(input logic [7:0] b, input int stall_mode, input bit with_start,
                              output int acc_edge);
        bit          stalled_once = 1'b0;
        bit          finished = 1'b0;
        bit          snap_valid = 1'b0;
        bit          stall;
        int          guard = 0;
        logic        snap_rdy, snap_busy;
        logic [15:0] snap_addr;
        acc_edge = -1;
        while (!finished) begin
            @(negedge clk);
            if (snap_valid) begin
                n_checks++;
                if (byte_rdy[0] !== snap_rdy || busy[0] !== snap_busy ||
                    wr_addr[0] !== snap_addr || wr_en[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_hold got rdy=%b busy=%b addr=%h wr_en=%b, required rdy=%b busy=%b addr=%h wr_en=0",
                             byte_rdy[0], busy[0], wr_addr[0], wr_en[0], snap_rdy, snap_busy, snap_addr);
                end
                snap_valid = 1'b0;
            end
            start = with_start;
            stall = (stall_mode == 1 && !stalled_once) ||
                    (stall_mode == 2 && $urandom_range(99) < 30);
            if (stall) begin
                stalled_once = 1'b1;
                byte_vld = 1'b0;
                byte_in  = 8'($urandom);
                if (wr_en[0] === 1'b0) begin
                    snap_rdy   = byte_rdy[0];
                    snap_busy  = busy[0];
                    snap_addr  = wr_addr[0];
                    snap_valid = 1'b1;
                end
            end else begin
                byte_vld = 1'b1;
                byte_in  = b;
                if (byte_rdy[0] === 1'b1) begin
                    acc_edge = cyc + 1;
                    finished = 1'b1;
                end
            end
            guard++;
            if (guard > 40 && !finished) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout got byte_rdy=0 for 40 cycles, required acceptance");
                finished = 1'b1;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        byte_vld = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (busy[k] !== 1'b1 || byte_rdy[k] !== 1'b1 || cpu_hold[k] !== 1'b1 ||
                err[k] !== 1'b0 || wr_addr[k] !== BASES[k]) begin
                n_fail++;
                $display("FAIL start_edge inst=%0d got busy=%b rdy=%b hold=%b err=%b addr=%h, required 1 1 1 0 %h",
                         k, busy[k], byte_rdy[k], cpu_hold[k], err[k], wr_addr[k], BASES[k]);
            end
        end
    endtask

    // Sends frame_words as one frame and checks writes, timing and completion against the model.
    task automatic run_frame(input bit use_chk, input logic [7:0] chk_in, input bit corrupt,
                             input int stall_mode, input bit poke_start);
        logic [7:0]  bytes[$];
        int          lo_edge[$];
        int          n = frame_words.size();
        logic [7:0]  sum = 8'h00;
        logic [7:0]  chk;
        bit          exp_err;
        int          e = -1;
        int          accepts = 0;
        int          idx[2] = '{0, 0};
        int          i, k;
        logic [15:0] ea;

        bytes.push_back(8'(n >> 8));
        bytes.push_back(8'(n));
        foreach (frame_words[j]) begin
            bytes.push_back(frame_words[j][15:8]);
            bytes.push_back(frame_words[j][7:0]);
        end
        foreach (bytes[j]) sum = sum + bytes[j];
        if (use_chk)
            chk = chk_in;
        else
            chk = corrupt ? (sum ^ 8'($urandom_range(1, 255))) : sum;
        exp_err = (chk != sum);
        bytes.push_back(chk);

        wq.delete();
        pulse_start();
        for (int b = 0; b < bytes.size(); b++) begin
            drive_byte(bytes[b], stall_mode, poke_start && (b == POS_DATA + 1), e);
            if (e >= 0) accepts++;
            if (b >= POS_DATA && (b % 2) == 1) lo_edge.push_back(e);
        end

        @(negedge clk);
        byte_vld = 1'b0;
        start    = 1'b0;
        n_checks++;
        if (accepts != frame_bytes(n)) begin
            n_fail++;
            $display("FAIL accept_count got %0d, required %0d", accepts, frame_bytes(n));
        end
        for (k = 0; k < 2; k++) begin
            n_checks++;
            if (done[k] !== 1'b1 || busy[k] !== 1'b0 || err[k] !== exp_err ||
                cpu_hold[k] !== exp_err || cyc != e) begin
                n_fail++;
                $display("FAIL done_pulse inst=%0d got done=%b busy=%b err=%b hold=%b cyc=%0d, required 1 0 %b %b cyc=%0d",
                         k, done[k], busy[k], err[k], cpu_hold[k], cyc, exp_err, exp_err, e);
            end
        end

        @(negedge clk);
        for (k = 0; k < 2; k++) begin
            n_checks++;
            if (done[k] !== 1'b0 || busy[k] !== 1'b0 || byte_rdy[k] !== 1'b0 ||
                err[k] !== exp_err || cpu_hold[k] !== exp_err) begin
                n_fail++;
                $display("FAIL after_done inst=%0d got done=%b busy=%b rdy=%b err=%b hold=%b, required 0 0 0 %b %b",
                         k, done[k], busy[k], byte_rdy[k], err[k], cpu_hold[k], exp_err, exp_err);
            end
        end

        foreach (wq[j]) begin
            k = wq[j].inst;
            i = idx[k];
            ea = BASES[k] + 16'(i);
            n_checks++;
            if (i >= n) begin
                n_fail++;
                $display("FAIL wr_extra inst=%0d got write addr=%h data=%h, required only %0d writes",
                         k, wq[j].addr, wq[j].data, n);
            end else if (wq[j].addr !== ea || wq[j].data !== frame_words[i] || wq[j].cyc != lo_edge[i]) begin
                n_fail++;
                $display("FAIL wr_seq inst=%0d idx=%0d got addr=%h data=%h cyc=%0d, required addr=%h data=%h cyc=%0d",
                         k, i, wq[j].addr, wq[j].data, wq[j].cyc, ea, frame_words[i], lo_edge[i]);
            end
            idx[k] = idx[k] + 1;
        end
        for (k = 0; k < 2; k++) begin
            n_checks++;
            if (idx[k] != n) begin
                n_fail++;
                $display("FAIL wr_count inst=%0d got %0d writes, required %0d", k, idx[k], n);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        byte_vld = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (byte_rdy[k] !== 1'b0 || wr_en[k] !== 1'b0 || busy[k] !== 1'b0 || done[k] !== 1'b0 ||
                err[k] !== 1'b0 || cpu_hold[k] !== 1'b1 || wr_addr[k] !== BASES[k] || wr_data[k] !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_state inst=%0d got rdy=%b wr=%b busy=%b done=%b err=%b hold=%b addr=%h data=%h, required 0 0 0 0 0 1 %h 0000",
                         k, byte_rdy[k], wr_en[k], busy[k], done[k], err[k], cpu_hold[k], wr_addr[k], wr_data[k], BASES[k]);
            end
        end
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (busy[k] !== 1'b0 || byte_rdy[k] !== 1'b0 || cpu_hold[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL post_reset_idle inst=%0d got busy=%b rdy=%b hold=%b, required 0 0 1",
                         k, busy[k], byte_rdy[k], cpu_hold[k]);
            end
        end
    endtask

    task automatic test_good_load();
        frame_words = '{16'hA1B2, 16'h0C0D};
        run_frame(1'b1, 8'h6E, 1'b0, 0, 1'b0);
    endtask

    task automatic test_bad_checksum();
        frame_words = '{16'hA1B2, 16'h0C0D};
        run_frame(1'b1, 8'h6F, 1'b0, 0, 1'b0);
    endtask

    task automatic test_zero_length_stalls();
        frame_words.delete();
        run_frame(1'b1, 8'h00, 1'b0, 1, 1'b0);
    endtask

    task automatic test_wrap();
        frame_words = '{16'h1122, 16'h3344};
        run_frame(1'b1, 8'hAC, 1'b0, 0, 1'b0);
    endtask

    task automatic test_mid_reset();
        int e;
        wq.delete();
        pulse_start();
        drive_byte(8'h00, 0, 1'b0, e);
        drive_byte(8'h02, 0, 1'b0, e);
        drive_byte(8'h12, 0, 1'b0, e);
        @(negedge clk);
        rst      = 1'b1;
        byte_vld = 1'b1;
        byte_in  = 8'h34;
        @(negedge clk);
        rst      = 1'b0;
        byte_vld = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (busy[k] !== 1'b0 || byte_rdy[k] !== 1'b0 || wr_en[k] !== 1'b0 || cpu_hold[k] !== 1'b1 ||
                done[k] !== 1'b0 || err[k] !== 1'b0 || wr_addr[k] !== BASES[k]) begin
                n_fail++;
                $display("FAIL mid_reset inst=%0d got busy=%b rdy=%b wr=%b hold=%b done=%b err=%b addr=%h, required 0 0 0 1 0 0 %h",
                         k, busy[k], byte_rdy[k], wr_en[k], cpu_hold[k], done[k], err[k], wr_addr[k], BASES[k]);
            end
        end
        @(negedge clk);
        n_checks++;
        if (wq.size() != 0) begin
            n_fail++;
            $display("FAIL pending_write_after_reset got %0d writes, required 0", wq.size());
        end
        frame_words = '{16'h5A5A, 16'hC3E1, 16'h0001};
        run_frame(1'b0, 8'h00, 1'b0, 0, 1'b0);
    endtask

    task automatic test_start_ignored();
        frame_words = '{16'hBEEF, 16'h0102, 16'h0304};
        run_frame(1'b0, 8'h00, 1'b0, 0, 1'b1);
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(0, 6);
            frame_words.delete();
            for (int j = 0; j < n; j++) frame_words.push_back(16'($urandom));
            run_frame(1'b0, 8'h00, ($urandom_range(0, 2) == 0), 2, ($urandom_range(0, 1) == 1));
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_zero_length_stalls();
        test_wrap();
        test_mid_reset();
        test_start_ignored();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
